// File: rtl/bnn_pkg.sv
// ---------------------------------------------------------------------------
// bnn_pkg : shared widths, width helpers and activation word type
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package bnn_pkg;

  localparam int PACK_W_DEF = 16;

  typedef logic [PACK_W_DEF-1:0] act_word_t;

  // The +1 bit holds the full-scale popcount value.
  function automatic int calc_pop_w(input int pop_size);
    return $clog2(pop_size) + 1;
  endfunction

  function automatic int calc_acc_w(input int pop_w, input int num_chunks);
    return pop_w + $clog2(num_chunks);
  endfunction

endpackage

`default_nettype wire

// File: rtl/bin_threshold.sv
// ---------------------------------------------------------------------------
// bin_threshold : folded batch-norm threshold and sign, one activation bit
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module bin_threshold #(
  parameter int ACC_W = 13
) (
  input  logic [ACC_W-1:0] sum_i,
  input  logic [ACC_W-1:0] thr_i,
  input  logic             thr_flip_i,
  output logic             act_bit_o
);

  assign act_bit_o = (sum_i >= thr_i) ^ thr_flip_i;

endmodule

`default_nettype wire

// File: rtl/popcount_threshold_pack.sv
// ---------------------------------------------------------------------------
// popcount_threshold_pack : chunk accumulate, threshold, pack LSB-first words
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module popcount_threshold_pack
  import bnn_pkg::*;
#(
  parameter int POP_SIZE   = 576,
  parameter int NUM_CHUNKS = 4,
  parameter int PACK_W     = PACK_W_DEF,
  parameter int POP_W      = calc_pop_w(POP_SIZE),
  parameter int ACC_W      = calc_acc_w(POP_W, NUM_CHUNKS),
  parameter int CNT_W      = $clog2(PACK_W) + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              pop_valid,
  output logic              pop_ready,
  input  logic [POP_W-1:0]  pop,
  input  logic              pop_last,
  input  logic [ACC_W-1:0]  thr,
  input  logic              thr_flip,
  input  logic              flush,
  output logic              act_valid,
  input  logic              act_ready,
  output logic [PACK_W-1:0] act_word,
  output logic [CNT_W-1:0]  act_nbits,
  output logic              err_chunks
);

  localparam int                CC_W    = $clog2(NUM_CHUNKS + 1) + 1;
  localparam logic [CC_W-1:0]   C_MAXCH = CC_W'(NUM_CHUNKS);
  localparam logic [CNT_W-1:0]  C_FULL  = CNT_W'(PACK_W);
  localparam int                IDX_W   = (PACK_W > 1) ? $clog2(PACK_W) : 1;

  logic [ACC_W-1:0]  acc_q, acc_d;
  logic [CC_W-1:0]   chunk_q, chunk_d;
  logic [PACK_W-1:0] pack_q, pack_d;
  logic [CNT_W-1:0]  idx_q, idx_d;
  logic              act_valid_q, act_valid_d;
  logic [PACK_W-1:0] act_word_q, act_word_d;
  logic [CNT_W-1:0]  act_nbits_q, act_nbits_d;
  logic              err_q, err_d;

  logic              accept;
  logic              last_acc;
  logic              flush_acc;
  logic              emit;
  logic [ACC_W-1:0]  sum;
  logic              act_bit;
  logic [PACK_W-1:0] pack_wr;
  logic [CNT_W-1:0]  idx_wr;

  assign pop_ready = !act_valid_q || act_ready;
  assign accept    = pop_valid && pop_ready;
  assign last_acc  = accept && pop_last;
  assign flush_acc = flush && pop_ready;
  assign sum       = acc_q + {{(ACC_W-POP_W){1'b0}}, pop};

  bin_threshold #(
    .ACC_W (ACC_W)
  ) u_thr (
    .sum_i      (sum),
    .thr_i      (thr),
    .thr_flip_i (thr_flip),
    .act_bit_o  (act_bit)
  );

  // Pack image including this cycle's bit, used both to store and to emit.
  always_comb begin
    pack_wr = pack_q;
    idx_wr  = idx_q;
    if (last_acc) begin
      pack_wr[idx_q[IDX_W-1:0]] = act_bit;
      idx_wr                    = idx_q + 1'b1;
    end
  end

  assign emit = (last_acc && (idx_wr == C_FULL)) ||
                (flush_acc && (idx_wr != '0));

  always_comb begin
    acc_d       = acc_q;
    chunk_d     = chunk_q;
    err_d       = err_q;
    pack_d      = pack_wr;
    idx_d       = idx_wr;
    act_valid_d = act_valid_q;
    act_word_d  = act_word_q;
    act_nbits_d = act_nbits_q;

    if (accept) begin
      if (pop_last) begin
        acc_d   = '0;
        chunk_d = '0;
      end else begin
        acc_d = sum;
        if (chunk_q >= C_MAXCH) err_d = 1'b1;
        else                    chunk_d = chunk_q + 1'b1;
      end
    end

    if (emit) begin
      act_valid_d = 1'b1;
      act_word_d  = pack_wr;
      act_nbits_d = idx_wr;
      pack_d      = '0;
      idx_d       = '0;
    end else if (act_ready) begin
      act_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q       <= '0;
      chunk_q     <= '0;
      pack_q      <= '0;
      idx_q       <= '0;
      act_valid_q <= 1'b0;
      act_word_q  <= '0;
      act_nbits_q <= '0;
      err_q       <= 1'b0;
    end else begin
      acc_q       <= acc_d;
      chunk_q     <= chunk_d;
      pack_q      <= pack_d;
      idx_q       <= idx_d;
      act_valid_q <= act_valid_d;
      act_word_q  <= act_word_d;
      act_nbits_q <= act_nbits_d;
      err_q       <= err_d;
    end
  end

  assign act_valid  = act_valid_q;
  assign act_word   = act_word_q;
  assign act_nbits  = act_nbits_q;
  assign err_chunks = err_q;

endmodule

`default_nettype wire
